status_register_unit: RTL and testbench

Writer side of the condition-evaluation path. It computes the {z,c,n,v} flags for flag-setting instructions leaving the EXE stage, holds them in a one-entry pending stage, and commits them to the architectural status register. It drives the packed 4-bit status word that the condition checker consumes. It forwards uncommitted flags so that back-to-back flag producers and consumers see the youngest value.

---
 rtl/status_register_unit_pkg.sv | 36 +++
 rtl/status_register_unit_flag_calc.sv | 85 ++++++++
 rtl/status_register_unit.sv | 95 +++++++++
 tb/tb_status_register_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/status_register_unit_pkg.sv
// ---------------------------------------------------------------------------
// status_register_unit_pkg
//
// Shared definitions for the status-flag writer path and its consumers.
//   - op_kind encodings (OP_NONE .. OP_SBC; encoding 7 is reserved and
//     behaves as OP_NONE).
//   - Flag bit positions inside the packed {z,c,n,v} status word, so the
//     condition checker and the writer agree on the packing.
//   - is_capture_op(): decides whether an instruction produces new flags,
//     ignoring the pipeline qualifiers (valid/flush/stall).
// ---------------------------------------------------------------------------
package status_register_unit_pkg;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_LOGIC = 3'd3;
    localparam logic [2:0] OP_MSRF  = 3'd4;
    localparam logic [2:0] OP_ADC   = 3'd5;
    localparam logic [2:0] OP_SBC   = 3'd6;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    // MSRF writes flags regardless of s_bit; every other flag-producing op
    // needs s_bit. NONE and the reserved encoding never write flags.
    function automatic logic is_capture_op(input logic s_bit, input logic [2:0] op);
        logic s_op;
        s_op = (op == OP_ADD) || (op == OP_SUB) || (op == OP_LOGIC) ||
               (op == OP_ADC) || (op == OP_SBC);
        return (s_bit && s_op) || (op == OP_MSRF);
    endfunction

endpackage

// File: rtl/status_register_unit_flag_calc.sv
// ---------------------------------------------------------------------------
// flag_calc
//
// Purely combinational flag generator for one EXE-stage instruction.
// Ports:
//   op_kind_i        op_kind encoding (see package)
//   operand_a_i      first ALU operand
//   operand_b_i      second ALU operand (post-shifter)
//   logic_result_i   ALU result, used for LOGIC
//   shifter_carry_i  shifter carry-out, used for LOGIC
//   msr_flags_i      direct {z,c,n,v} value for MSRF
//   cin_i            forwarded carry flag (for ADC/SBC)
//   vin_i            forwarded overflow flag (LOGIC keeps it)
//   flags_o          computed {z,c,n,v}
// ---------------------------------------------------------------------------
module flag_calc
    import status_register_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        op_kind_i,
    input  logic [DATA_W-1:0] operand_a_i,
    input  logic [DATA_W-1:0] operand_b_i,
    input  logic [DATA_W-1:0] logic_result_i,
    input  logic              shifter_carry_i,
    input  logic [3:0]        msr_flags_i,
    input  logic              cin_i,
    input  logic              vin_i,
    output logic [3:0]        flags_o
);

    localparam int MSB = DATA_W - 1;

    logic              is_sub;
    logic              carry_in;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] res;
    logic              v_add;
    logic              v_sub;

    // One shared adder: subtraction is a + ~b + carry, where the carry is 1
    // for SUB (two's complement) and the forwarded carry for SBC.
    always_comb begin
        is_sub   = (op_kind_i == OP_SUB) || (op_kind_i == OP_SBC);
        b_eff    = is_sub ? ~operand_b_i : operand_b_i;
        carry_in = (op_kind_i == OP_ADD) ? 1'b0 :
                   (op_kind_i == OP_SUB) ? 1'b1 : cin_i;
        sum      = {1'b0, operand_a_i} + {1'b0, b_eff} + {{DATA_W{1'b0}}, carry_in};
        res      = sum[DATA_W-1:0];
        v_add    = (operand_a_i[MSB] == operand_b_i[MSB]) && (res[MSB] != operand_a_i[MSB]);
        v_sub    = (operand_a_i[MSB] != operand_b_i[MSB]) && (res[MSB] != operand_a_i[MSB]);
    end

    always_comb begin
        flags_o = 4'b0000;
        case (op_kind_i)
            OP_ADD, OP_ADC: begin
                flags_o[FLAG_Z] = (res == '0);
                flags_o[FLAG_C] = sum[DATA_W];
                flags_o[FLAG_N] = res[MSB];
                flags_o[FLAG_V] = v_add;
            end
            OP_SUB, OP_SBC: begin
                flags_o[FLAG_Z] = (res == '0);
                flags_o[FLAG_C] = sum[DATA_W];
                flags_o[FLAG_N] = res[MSB];
                flags_o[FLAG_V] = v_sub;
            end
            OP_LOGIC: begin
                flags_o[FLAG_Z] = (logic_result_i == '0);
                flags_o[FLAG_C] = shifter_carry_i;
                flags_o[FLAG_N] = logic_result_i[MSB];
                flags_o[FLAG_V] = vin_i;
            end
            OP_MSRF: begin
                flags_o = msr_flags_i;
            end
            default: begin
                flags_o = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/status_register_unit.sv
// ---------------------------------------------------------------------------
// status_register_unit
//
// Computes {z,c,n,v} for flag-setting instructions leaving EXE, holds them in
// a one-entry pending stage, then commits them to the architectural status
// register. The pending value is forwarded so back-to-back producers and
// consumers see the youngest flags.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   exe_valid         EXE instruction valid
//   exe_flush         EXE instruction squashed
//   stall             pipeline frozen, no capture
//   s_bit             instruction requests flag update
//   op_kind           operation kind (see package)
//   operand_a/b       ALU operands
//   logic_result      ALU result for LOGIC
//   shifter_carry     shifter carry-out for LOGIC
//   msr_flags         direct flags for MSRF
//   status_out        forwarded status word {z,c,n,v}
//   status_arch       committed status register
//   flags_hazard      pending stage holds uncommitted flags
// ---------------------------------------------------------------------------
module status_register_unit
    import status_register_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exe_valid,
    input  logic              exe_flush,
    input  logic              stall,
    input  logic              s_bit,
    input  logic [2:0]        op_kind,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [DATA_W-1:0] logic_result,
    input  logic              shifter_carry,
    input  logic [3:0]        msr_flags,
    output logic [3:0]        status_out,
    output logic [3:0]        status_arch,
    output logic              flags_hazard
);

    logic       capture;
    logic [3:0] calc_flags;

    logic       pend_valid_q;
    logic [3:0] pend_flags_q;
    logic [3:0] pend_flags_d;
    logic [3:0] sr_q;
    logic [3:0] sr_d;

    assign capture = exe_valid && !exe_flush && !stall && is_capture_op(s_bit, op_kind);

    // Carry and overflow inputs come from the forwarded word so that an
    // ADC/SBC/LOGIC right behind another producer uses its fresh flags.
    flag_calc #(
        .DATA_W (DATA_W)
    ) u_flag_calc (
        .op_kind_i       (op_kind),
        .operand_a_i     (operand_a),
        .operand_b_i     (operand_b),
        .logic_result_i  (logic_result),
        .shifter_carry_i (shifter_carry),
        .msr_flags_i     (msr_flags),
        .cin_i           (status_out[FLAG_C]),
        .vin_i           (status_out[FLAG_V]),
        .flags_o         (calc_flags)
    );

    // The pending entry is older than anything in EXE, so it commits
    // unconditionally, independent of stall and flush.
    always_comb begin
        pend_flags_d = capture ? calc_flags : pend_flags_q;
        sr_d         = pend_valid_q ? pend_flags_q : sr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_flags_q <= 4'b0000;
            sr_q         <= 4'b0000;
        end else begin
            pend_valid_q <= capture;
            pend_flags_q <= pend_flags_d;
            sr_q         <= sr_d;
        end
    end

    assign status_out   = pend_valid_q ? pend_flags_q : sr_q;
    assign status_arch  = sr_q;
    assign flags_hazard = pend_valid_q;

endmodule

// File: tb/tb_status_register_unit.sv
// ---------------------------------------------------------------------------
// tb_status_register_unit
//
// Directed scenarios from the design's intended behaviour plus a randomized
// run checked against a reference model that works on integer arithmetic
// (signed/unsigned range checks) rather than on adder carry bits.
// ---------------------------------------------------------------------------
module tb_status_register_unit;

    logic        clk;
    logic        rst_n;
    logic        exe_valid;
    logic        exe_flush;
    logic        stall;
    logic        s_bit;
    logic [2:0]  op_kind;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] logic_result;
    logic        shifter_carry;
    logic [3:0]  msr_flags;
    logic [3:0]  status_out;
    logic [3:0]  status_arch;
    logic        flags_hazard;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [3:0] m_sr;
    logic [3:0] m_pend;
    logic       m_pv;

    status_register_unit #(.DATA_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .exe_valid     (exe_valid),
        .exe_flush     (exe_flush),
        .stall         (stall),
        .s_bit         (s_bit),
        .op_kind       (op_kind),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .logic_result  (logic_result),
        .shifter_carry (shifter_carry),
        .msr_flags     (msr_flags),
        .status_out    (status_out),
        .status_arch   (status_arch),
        .flags_hazard  (flags_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] m_out();
        return m_pv ? m_pend : m_sr;
    endfunction

    // Flags from plain integer arithmetic: carry = unsigned result fits
    // the 33-bit carry-out rule, overflow = signed result out of range.
    function automatic logic [3:0] ref_flags(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] lr,
                                             input logic sc, input logic [3:0] msr,
                                             input logic cin, input logic vin);
        longint ua, ub, sa, sb, ci, u, s;
        logic [31:0] r;
        logic c;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ci = cin ? 64'sd1 : 64'sd0;
        u = 0; s = 0; c = 1'b0;
        case (op)
            3'd1: begin u = ua + ub;          s = sa + sb;          c = (u >= 64'sd4294967296); end
            3'd5: begin u = ua + ub + ci;     s = sa + sb + ci;     c = (u >= 64'sd4294967296); end
            3'd2: begin u = ua - ub;          s = sa - sb;          c = (u >= 0); end
            3'd6: begin u = ua - ub - 1 + ci; s = sa - sb - 1 + ci; c = (u >= 0); end
            3'd3: return {(lr == 32'd0), sc, lr[31], vin};
            3'd4: return msr;
            default: return 4'b0000;
        endcase
        r = u[31:0];
        return {(r == 32'd0), c, r[31], (s > 64'sd2147483647) || (s < -64'sd2147483648)};
    endfunction

    // Drive one cycle of EXE inputs, advance the model across the rising
    // edge, and leave time at edge+1 for the caller's comparisons.
    task automatic drive(input logic ev, input logic fl, input logic st, input logic sb,
                         input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lr, input logic sc, input logic [3:0] msr);
        logic cap;
        logic [3:0] nf;
        logic [3:0] cur;
        exe_valid = ev; exe_flush = fl; stall = st; s_bit = sb; op_kind = op;
        operand_a = a; operand_b = b; logic_result = lr; shifter_carry = sc; msr_flags = msr;
        cur = m_out();
        cap = ev && !fl && !st &&
              ((sb && (op == 3'd1 || op == 3'd2 || op == 3'd3 || op == 3'd5 || op == 3'd6)) ||
               op == 3'd4);
        nf = ref_flags(op, a, b, lr, sc, msr, cur[2], cur[0]);
        @(posedge clk);
        if (m_pv) m_sr = m_pend;
        if (cap) m_pend = nf;
        m_pv = cap;
        #1;
        $display("txn v=%0b f=%0b st=%0b s=%0b op=%0d a=%08h b=%08h -> out=%04b arch=%04b hz=%0b",
                 ev, fl, st, sb, op, a, b, status_out, status_arch, flags_hazard);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0000);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        exe_valid = 0; exe_flush = 0; stall = 0; s_bit = 0; op_kind = 0;
        operand_a = 0; operand_b = 0; logic_result = 0; shifter_carry = 0; msr_flags = 0;
        m_sr = 4'b0000; m_pend = 4'b0000; m_pv = 1'b0;
        #12;
        total++;
        if ({status_out, status_arch, flags_hazard} !== 9'b0) begin
            bad++;
            $display("FAIL reset_idle got out=%04b arch=%04b hz=%0b want 0000 0000 0",
                     status_out, status_arch, flags_hazard);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_overflow();
        drive(1, 0, 0, 1, 3'd1, 32'h7FFFFFFF, 32'h1, 0, 0, 0);
        total++;
        if ({status_out, status_arch, flags_hazard} !== {4'b0011, 4'b0000, 1'b1}) begin
            bad++;
            $display("FAIL add_ovf_fwd got out=%04b arch=%04b hz=%0b want 0011 0000 1",
                     status_out, status_arch, flags_hazard);
        end
        idle();
        total++;
        if ({status_out, status_arch, flags_hazard} !== {4'b0011, 4'b0011, 1'b0}) begin
            bad++;
            $display("FAIL add_ovf_commit got out=%04b arch=%04b hz=%0b want 0011 0011 0",
                     status_out, status_arch, flags_hazard);
        end
    endtask

    task automatic test_sub();
        drive(1, 0, 0, 1, 3'd2, 32'd5, 32'd5, 0, 0, 0);
        total++;
        if (status_out !== 4'b1100) begin
            bad++;
            $display("FAIL sub_equal got %04b want 1100", status_out);
        end
        drive(1, 0, 0, 1, 3'd2, 32'd3, 32'd5, 0, 0, 0);
        total++;
        if ({status_out, status_arch} !== {4'b0010, 4'b1100}) begin
            bad++;
            $display("FAIL sub_borrow got out=%04b arch=%04b want 0010 1100", status_out, status_arch);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 0, 1, 3'd1, 32'hFFFFFFFF, 32'h1, 0, 0, 0);
        total++;
        if (status_out !== 4'b1100) begin
            bad++;
            $display("FAIL wrap_add got %04b want 1100", status_out);
        end
        drive(1, 0, 0, 1, 3'd5, 32'd0, 32'd0, 0, 0, 0);
        total++;
        if ({status_out, status_arch, flags_hazard} !== {4'b0000, 4'b1100, 1'b1}) begin
            bad++;
            $display("FAIL adc_fwd_carry got out=%04b arch=%04b hz=%0b want 0000 1100 1",
                     status_out, status_arch, flags_hazard);
        end
        idle();
        total++;
        if (status_arch !== 4'b0000) begin
            bad++;
            $display("FAIL adc_commit got %04b want 0000", status_arch);
        end
    endtask

    task automatic test_logic_msrf();
        drive(1, 0, 0, 0, 3'd4, 0, 0, 0, 0, 4'b0001);
        drive(1, 0, 0, 1, 3'd3, 0, 0, 32'd0, 1'b1, 0);
        total++;
        if (status_out !== 4'b1101) begin
            bad++;
            $display("FAIL logic_vkeep got %04b want 1101", status_out);
        end
        drive(1, 0, 0, 0, 3'd4, 0, 0, 0, 0, 4'b0110);
        total++;
        if (status_out !== 4'b0110) begin
            bad++;
            $display("FAIL msrf_nos got %04b want 0110", status_out);
        end
        idle();
        // Non-capturing ops must leave sr alone.
        drive(1, 0, 0, 0, 3'd1, 32'hFFFFFFFF, 32'h1, 0, 0, 0);
        drive(1, 0, 0, 1, 3'd7, 32'd0, 32'd0, 0, 0, 4'b1111);
        drive(1, 0, 0, 1, 3'd0, 32'd0, 32'd0, 0, 0, 4'b1111);
        total++;
        if ({status_out, status_arch, flags_hazard} !== {4'b0110, 4'b0110, 1'b0}) begin
            bad++;
            $display("FAIL no_capture got out=%04b arch=%04b hz=%0b want 0110 0110 0",
                     status_out, status_arch, flags_hazard);
        end
    endtask

    task automatic test_flush_stall();
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 0, 1, 3'd2, 32'd3, 32'd5, 0, 0, 0);          // pending 0010
            drive(1, (k == 0), (k == 1), 1, 3'd1, 32'd0, 32'd0, 0, 0, 0); // would give 1000
            total++;
            if ({status_out, status_arch, flags_hazard} !== {4'b0010, 4'b0010, 1'b0}) begin
                bad++;
                $display("FAIL %s_commit got out=%04b arch=%04b hz=%0b want 0010 0010 0",
                         (k == 0) ? "flush" : "stall", status_out, status_arch, flags_hazard);
            end
            idle();
            total++;
            if (status_arch !== 4'b0010) begin
                bad++;
                $display("FAIL %s_no_write got %04b want 0010",
                         (k == 0) ? "flush" : "stall", status_arch);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1, 0, 0, 0, 3'd4, 0, 0, 0, 0, 4'b1011);
        exe_valid = 0; op_kind = 0;
        #2;
        rst_n = 1'b0;
        m_sr = 4'b0000; m_pend = 4'b0000; m_pv = 1'b0;
        #1;
        total++;
        if ({status_out, status_arch, flags_hazard} !== 9'b0) begin
            bad++;
            $display("FAIL async_reset got out=%04b arch=%04b hz=%0b want 0000 0000 0",
                     status_out, status_arch, flags_hazard);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        idle();
        idle();
        total++;
        if ({status_out, status_arch, flags_hazard} !== 9'b0) begin
            bad++;
            $display("FAIL reset_no_commit got out=%04b arch=%04b hz=%0b want 0000 0000 0",
                     status_out, status_arch, flags_hazard);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h00000000;
            1: return 32'hFFFFFFFF;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            4: return 32'h00000001;
            default: return $urandom();
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                  pick_operand(), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)));
            total++;
            if ({status_out, status_arch, flags_hazard} !== {m_out(), m_sr, m_pv}) begin
                bad++;
                $display("FAIL random_%0d got out=%04b arch=%04b hz=%0b want %04b %04b %0b",
                         i, status_out, status_arch, flags_hazard, m_out(), m_sr, m_pv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub();
        test_back_to_back();
        test_logic_msrf();
        test_flush_stall();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
